micro_sequencer: RTL
====================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 next_adr  input  5  NextAdr field (bits [4:0]) of the current microword returned by the microcode ROM.
REQ-005 op  input  2  instruction bits [27:26] from the instruction register.
REQ-006 funct  input  6  instruction bits [25:20] from the instruction register.
REQ-007 stall  input  1  when high, all state holds (memory not ready).
REQ-008 adr  output  5  registered micro-PC, drives the microcode ROM address.
REQ-009 illegal  output  1  registered one-cycle pulse on an undecodable dispatch.
REQ-010 instr_count  output  16  registered count of decoded instructions.

Function
REQ-011 Microstate codes SHALL be: Fetch 00000, Decode 00001, MemAdr 00010, MemRead 00011, MemWB 00100, MemWrite 00101, ExecuteR 00110, ExecuteI 00111, ALUWB 01000, Branch 01001, BL 01010, MemReadByte 01011.
REQ-012 Each rising edge with stall low SHALL load adr with the computed next state; with stall high, adr, illegal (forced 0), instr_count and latched fields SHALL hold.
REQ-013 next_adr 11111 SHALL select dispatch 1; next_adr 11110 SHALL select dispatch 2; next_adr 00000-01011 SHALL be used directly; next_adr 01100-11101 SHALL go to Fetch and pulse illegal.
REQ-014 Dispatch 1 on op: 00 with funct[5]=1 -> ExecuteI; 00 with funct[5]=0 -> ExecuteR; 01 -> MemAdr; 10 with funct[4]=1 -> BL; 10 with funct[4]=0 -> Branch; 11 -> Fetch and pulse illegal.
REQ-015 When adr=Decode and stall is low, op and funct SHALL be latched into internal registers op_q and funct_q on that edge.
REQ-016 Dispatch 1 SHALL use the live op/funct inputs; dispatch 2 SHALL use only funct_q.
REQ-017 Dispatch 2 (L=funct_q[0], B=funct_q[2]): L=1,B=0 -> MemRead; L=1,B=1 -> MemReadByte; L=0,B=0 -> MemWrite; L=0,B=1 (STRB, unsupported) -> Fetch and pulse illegal.
REQ-018 illegal SHALL be 1 for exactly the cycle after the offending edge, and 0 otherwise.
REQ-019 instr_count SHALL increment by 1 on each unstalled edge with adr=Decode, including edges that flag illegal, and SHALL wrap from FFFF to 0000.
REQ-020 Latency SHALL be one cycle: the next state is visible on adr one clock after the ROM word is presented; there is no combinational path from inputs to outputs.
REQ-021 If a stall covers the Decode state, the fields SHALL be latched only on the final (unstalled) edge.

Reset
REQ-022 While reset_n is low, adr SHALL be 00000, illegal 0, instr_count 0000, op_q 00 and funct_q 000000, regardless of clk.
REQ-023 On reset_n deassertion, the first rising edge SHALL evaluate from Fetch; asserting reset mid-instruction SHALL abort it immediately, with no pending illegal pulse.

Verification
REQ-024 Data-processing immediate: reset release, op=00, funct=100000, ROM words per REQ-011 -> adr sequence 00,01,07,08,00; instr_count=1; illegal never set.
REQ-025 LDRB then LDR: op=01, funct=000101 -> 00,01,02,0B,04,00; then funct=000001 -> 00,01,02,03,04,00; instr_count=2.
REQ-026 STR and STRB: funct=000000 -> 00,01,02,05,00; funct=000100 -> 00,01,02,00, with illegal high for one cycle while adr=00.
REQ-027 BL plus illegal op: op=10, funct=010000 -> 00,01,0A,00; op=11 -> 00,01,00, with illegal pulse; next_adr=01111 from any state -> Fetch and illegal pulse.
REQ-028 Stall and funct change: stall held 3 cycles in MemAdr while funct changes to 000000 after Decode -> adr stays 02 for 3 cycles, then goes to MemRead (uses funct_q); instr_count unchanged by the stall.
REQ-029 Reset and wrap: preload instr_count to FFFF via 65535 decodes, one more decode -> 0000; reset_n pulsed low mid-MemRead -> adr=00, outputs cleared asynchronously.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC sequencer with two dispatch decoders, illegal-dispatch flag and decode counter
module micro_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  next_adr,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic        stall,
  output logic [4:0]  adr,
  output logic        illegal,
  output logic [15:0] instr_count
);
  localparam logic [4:0] FETCH = 5'd0, DECODE = 5'd1, MEM_ADR = 5'd2, MEM_READ = 5'd3;
  localparam logic [4:0] MEM_WRITE = 5'd5, EXECUTE_R = 5'd6, EXECUTE_I = 5'd7;
  localparam logic [4:0] BRANCH = 5'd9, BL = 5'd10, MEM_READ_BYTE = 5'd11;
  localparam logic [4:0] DISP1 = 5'b11111, DISP2 = 5'b11110;
  logic [1:0] op_q;
  logic [5:0] funct_q;
  logic [4:0] d1, d2, nxt;
  logic bad;
  logic unused_fields;
  assign unused_fields = ^{op_q, funct_q[5:3], funct_q[1]};
  // next micro-PC: dispatch 1 on live op/funct, dispatch 2 on latched funct, otherwise the ROM word itself
  always_comb begin
    d1 = op == 2'b00 ? (funct[5] ? EXECUTE_I : EXECUTE_R) : op == 2'b01 ? MEM_ADR : op == 2'b10 ? (funct[4] ? BL : BRANCH) : FETCH;
    d2 = funct_q[0] ? (funct_q[2] ? MEM_READ_BYTE : MEM_READ) : (funct_q[2] ? FETCH : MEM_WRITE);
    bad = next_adr == DISP1 ? op == 2'b11 : next_adr == DISP2 ? (!funct_q[0] && funct_q[2]) : next_adr > MEM_READ_BYTE;
    nxt = next_adr == DISP1 ? d1 : next_adr == DISP2 ? d2 : next_adr > MEM_READ_BYTE ? FETCH : next_adr;
  end
  // state update: stall freezes everything and drops illegal; Decode edges count and capture the fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adr <= FETCH;
      illegal <= 1'b0;
      instr_count <= '0;
      op_q <= '0;
      funct_q <= '0;
    end else if (stall) begin
      illegal <= 1'b0;
    end else begin
      adr <= nxt;
      illegal <= bad;
      if (adr == DECODE) begin
        instr_count <= instr_count + 16'd1;
        op_q <= op;
        funct_q <= funct;
      end
    end
  end
endmodule
